// File: rtl/gpio_bus_pkg.sv
// Shared types for the peripheral bus master: op codes, FSM states, queued command
// layout and GPIO register offsets used by software and benches.
package gpio_bus_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RMW_WR,
        RSP
    } state_e;

    localparam logic [31:0] GPIO_DATA = 32'h0000_0000;
    localparam logic [31:0] GPIO_DIR  = 32'h0000_0004;
    localparam logic [31:0] GPIO_READ = 32'h0000_0008;

    typedef struct packed {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    function automatic logic [31:0] rmw_merge(input op_e op, input logic [31:0] rd,
                                              input logic [31:0] mask);
        return (op == OP_SET) ? (rd | mask) : (rd & ~mask);
    endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Generic synchronous FIFO; head visible combinationally, pop/push take effect at the edge.
// Backpressure: full blocks push (no bypass); extra pointer bit distinguishes full from empty.
module bus_cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_rdy && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_vld && !full)
            mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/gpio_bus_master.sv
// Queues commands and issues them on the single-cycle peripheral bus; 3 cycles/op (4 for SET/CLR).
// Backpressure: cmd_ready drops only when the FIFO is full; a held response stalls all bus traffic.
module gpio_bus_master
    import gpio_bus_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [1:0]  rsp_op,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);
    state_e      state_q, state_d;
    op_e         op_q;
    logic [31:0] addr_q, data_q, rdata_q;

    cmd_t push_cmd, head_cmd;
    logic fifo_full, fifo_empty, pop;

    assign push_cmd  = '{op: op_e'(cmd_op), addr: cmd_addr, data: cmd_wdata};
    assign cmd_ready = !rst && !fifo_full;
    assign busy      = !fifo_empty || (state_q != IDLE);

    bus_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (cmd_valid && cmd_ready),
        .wr_dat (push_cmd),
        .rd_rdy (pop),
        .rd_dat (head_cmd),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_WRITE;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                op_q   <= head_cmd.op;
                addr_q <= head_cmd.addr;
                data_q <= head_cmd.data;
            end
            // bus_rdata is combinational from the target, so it is valid in the ISSUE cycle itself.
            if (state_q == ISSUE && op_q != OP_WRITE)
                rdata_q <= bus_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        rsp_valid = 1'b0;
        rsp_op    = '0;
        rsp_rdata = '0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus_valid = 1'b1;
                bus_addr  = addr_q;
                if (op_q == OP_WRITE) begin
                    bus_we    = 1'b1;
                    bus_wdata = data_q;
                    state_d   = RSP;
                end else if (op_q == OP_READ) begin
                    state_d = RSP;
                end else begin
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                bus_valid = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = addr_q;
                bus_wdata = rmw_merge(op_q, rdata_q, data_q);
                state_d   = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_op    = op_q;
                rsp_rdata = (op_q == OP_WRITE) ? data_q : rdata_q;
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master against a small GPIO register model; responses checked via scoreboard.
module tb_gpio_bus_master;
    import gpio_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    gpio_bus_master #(.CMD_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_op    (rsp_op),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // GPIO peripheral model
    logic [31:0] g_data = '0;
    logic [31:0] g_dir  = '0;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    assign gpio_out = g_data & g_dir;

    always_comb begin
        case (bus_addr)
            GPIO_DATA: bus_rdata = g_data;
            GPIO_DIR:  bus_rdata = g_dir;
            GPIO_READ: bus_rdata = (gpio_in & ~g_dir) | (g_data & g_dir);
            default:   bus_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (bus_valid && bus_we) begin
            if (bus_addr == GPIO_DATA) g_data <= bus_wdata;
            if (bus_addr == GPIO_DIR)  g_dir  <= bus_wdata;
        end
    end

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_ev_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bus_cnt = 0;
    int          wr_cnt = 0;
    int          rsp_cnt = 0;
    int          acc_cyc = 0;
    int          rsp_rise_cyc = -1;
    logic [33:0] sb[$];
    bus_ev_t     bus_log[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: bus activity log, scoreboard compare, response stability while stalled.
    initial begin
        logic        rsp_prev;
        logic        held;
        logic [33:0] held_val;
        logic [33:0] exp;
        rsp_prev = 1'b0;
        held     = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            if (bus_valid) begin
                bus_cnt++;
                if (bus_we) wr_cnt++;
                bus_log.push_back('{cyc, bus_we, bus_addr, bus_wdata});
            end
            if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
            rsp_prev = rsp_valid;
            if (rsp_valid && !rsp_ready) begin
                if (held) begin
                    checks++;
                    if ({rsp_op, rsp_rdata} !== held_val) begin
                        errors++;
                        $display("FAIL rsp_stable: got %h, held %h", {rsp_op, rsp_rdata}, held_val);
                    end
                end
                held     = 1'b1;
                held_val = {rsp_op, rsp_rdata};
            end else begin
                held = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got op=%0d rdata=%h, none expected", rsp_op, rsp_rdata);
                end else begin
                    exp = sb.pop_front();
                    if ({rsp_op, rsp_rdata} !== exp) begin
                        errors++;
                        $display("FAIL rsp_data: got op=%0d rdata=%h, expected op=%0d rdata=%h",
                                 rsp_op, rsp_rdata, exp[33:32], exp[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rd);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back({op, exp_rd});
            acc_cyc = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%0d, required 1 within 100 cycles", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: busy=%0d pending=%0d, required idle", name, busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, rsp_op, rsp_rdata, busy, bus_valid, bus_we, bus_addr, bus_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cmd_ready=%0d rsp_valid=%0d busy=%0d bus_valid=%0d, required all 0",
                     cmd_ready, rsp_valid, busy, bus_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %0d, required 1", cmd_ready);
        end
        checks++;
        if (busy !== 1'b0 || bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%0d bus_valid=%0d, required 0 0", busy, bus_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int b0, w0;
        b0 = bus_cnt;
        w0 = wr_cnt;
        send_cmd(OP_WRITE, GPIO_DIR, 32'h0000_00FF, 32'h0000_00FF);
        send_cmd(OP_WRITE, GPIO_DATA, 32'h0000_00A5, 32'h0000_00A5);
        drain("write");
        checks++;
        if (bus_cnt - b0 != 2 || wr_cnt - w0 != 2) begin
            errors++;
            $display("FAIL write_bus_cycles: got %0d/%0d writes, required 2/2", bus_cnt - b0, wr_cnt - w0);
        end
        checks++;
        if (gpio_out !== 32'h0000_00A5) begin
            errors++;
            $display("FAIL write_gpio_out: got %h, required 000000a5", gpio_out);
        end
    endtask

    task automatic test_read();
        int b0, w0;
        b0 = bus_cnt;
        w0 = wr_cnt;
        gpio_in = 32'h1234_5600;
        bus_log.delete();
        rsp_rise_cyc = -1;
        send_cmd(OP_READ, GPIO_READ, 32'hDEAD_BEEF, 32'h1234_56A5);
        drain("read");
        checks++;
        if (bus_cnt - b0 != 1 || wr_cnt - w0 != 0) begin
            errors++;
            $display("FAIL read_bus_cycles: got %0d accesses %0d writes, required 1 0", bus_cnt - b0, wr_cnt - w0);
        end
        checks++;
        if (bus_log.size() != 1 || bus_log[0].cyc != acc_cyc + 2) begin
            errors++;
            $display("FAIL read_issue_cycle: got log=%0d offset=%0d, required 1 entry at +2",
                     bus_log.size(), (bus_log.size() > 0) ? bus_log[0].cyc - acc_cyc : -1);
        end
        checks++;
        if (rsp_rise_cyc != acc_cyc + 3) begin
            errors++;
            $display("FAIL read_rsp_latency: got +%0d, required +3", rsp_rise_cyc - acc_cyc);
        end
    endtask

    task automatic test_rmw();
        bus_log.delete();
        send_cmd(OP_SET, GPIO_DATA, 32'h0000_0F00, 32'h0000_00A5);
        send_cmd(OP_CLR, GPIO_DATA, 32'h0000_0005, 32'h0000_0FA5);
        drain("rmw");
        checks++;
        if (bus_log.size() != 4) begin
            errors++;
            $display("FAIL rmw_access_count: got %0d, required 4", bus_log.size());
        end else begin
            checks++;
            if (bus_log[0].we !== 1'b0 || bus_log[1].we !== 1'b1 || bus_log[1].cyc != bus_log[0].cyc + 1
                || bus_log[1].wdata !== 32'h0000_0FA5) begin
                errors++;
                $display("FAIL set_sequence: we=%0d,%0d gap=%0d wdata=%h, required 0,1 gap 1 wdata 00000fa5",
                         bus_log[0].we, bus_log[1].we, bus_log[1].cyc - bus_log[0].cyc, bus_log[1].wdata);
            end
            checks++;
            if (bus_log[2].we !== 1'b0 || bus_log[3].we !== 1'b1 || bus_log[3].cyc != bus_log[2].cyc + 1
                || bus_log[3].wdata !== 32'h0000_0FA0) begin
                errors++;
                $display("FAIL clr_sequence: we=%0d,%0d gap=%0d wdata=%h, required 0,1 gap 1 wdata 00000fa0",
                         bus_log[2].we, bus_log[3].we, bus_log[3].cyc - bus_log[2].cyc, bus_log[3].wdata);
            end
        end
        checks++;
        if (g_data !== 32'h0000_0FA0) begin
            errors++;
            $display("FAIL rmw_gpio_data: got %h, required 00000fa0", g_data);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        int b0, r0;
        logic stalled;
        addrs[0] = GPIO_DATA; exps[0] = 32'h0000_0FA0;
        addrs[1] = GPIO_DIR;  exps[1] = 32'h0000_00FF;
        addrs[2] = GPIO_READ; exps[2] = 32'h1234_56A0;
        b0 = bus_cnt;
        r0 = rsp_cnt;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send_cmd(OP_READ, addrs[k % 3], '0, exps[k % 3]);
        cmd_valid = 1'b1;
        cmd_op    = OP_READ;
        cmd_addr  = addrs[2];
        cmd_wdata = '0;
        stalled   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0) stalled = 1'b0;
        end
        checks++;
        if (!stalled) begin
            errors++;
            $display("FAIL full_ready: cmd_ready went high with FIFO full, required 0");
        end
        checks++;
        if (bus_cnt - b0 != 1) begin
            errors++;
            $display("FAIL stall_bus_cycles: got %0d, required 1", bus_cnt - b0);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0FA0) begin
            errors++;
            $display("FAIL stall_rsp: valid=%0d rdata=%h, required 1 00000fa0", rsp_valid, rsp_rdata);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        send_cmd(OP_READ, addrs[2], '0, exps[2]);
        drain("backpressure");
        checks++;
        if (bus_cnt - b0 != 6 || rsp_cnt - r0 != 6) begin
            errors++;
            $display("FAIL bp_totals: got %0d accesses %0d responses, required 6 6", bus_cnt - b0, rsp_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        int b0, w0, r0;
        logic found;
        w0 = wr_cnt;
        rsp_ready = 1'b0;
        send_cmd(OP_READ, GPIO_DIR, '0, 32'h0000_00FF);
        send_cmd(OP_SET, GPIO_DATA, 32'h0000_00F0, 32'h0000_0FA0);
        send_cmd(OP_WRITE, GPIO_DIR, 32'h0, 32'h0);
        send_cmd(OP_READ, GPIO_DATA, '0, 32'h0000_0FA0);
        rsp_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_valid && !bus_we && bus_addr == GPIO_DATA) begin
                found = 1'b1;
                rst = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL set_issue_seen: no SET read within 50 cycles");
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        b0 = bus_cnt;
        r0 = rsp_cnt;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%0d rsp_valid=%0d, required 0 0", busy, rsp_valid);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (bus_cnt != b0 || rsp_cnt != r0 || wr_cnt != w0) begin
            errors++;
            $display("FAIL mid_reset_quiet: +%0d accesses +%0d rsps +%0d writes, required 0 0 0",
                     bus_cnt - b0, rsp_cnt - r0, wr_cnt - w0);
        end
        checks++;
        if (g_data !== 32'h0000_0FA0 || g_dir !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL mid_reset_regs: data=%h dir=%h, required 00000fa0 000000ff", g_data, g_dir);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_rmw();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
